// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD datapath blocks.
// Slot occupancy state and demux select encoding.
package gcd_pkg;

    localparam int GCD_WIDTH = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

endpackage

// File: rtl/gcd_demux_slot.sv
// One-entry holding slot with load/drain handshake and optional drain counter (GCD_DEMUX_COUNT_EN).
// Latency: loaded value visible on x_data/x_valid one cycle after the load edge.
// Backpressure: can_load is low only while full and the consumer is not taking the value.
module gcd_demux_slot
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
`ifdef GCD_DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             can_load,
    output logic [WIDTH-1:0] x_data,
    output logic             x_valid,
    input  logic             x_ready
`ifdef GCD_DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] x_count
`endif
);

    slot_state_t state;
    logic        drain;

    assign drain    = x_valid && x_ready;
    assign can_load = !x_valid || x_ready;

    // load is only asserted while can_load is high, so a load in FULL always coincides with a drain
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SLOT_EMPTY;
            x_valid <= 1'b0;
            x_data  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state   <= SLOT_FULL;
                        x_valid <= 1'b1;
                        x_data  <= load_data;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        x_data <= load_data;
                    end else if (drain) begin
                        state   <= SLOT_EMPTY;
                        x_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= SLOT_EMPTY;
                    x_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_DEMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            x_count <= '0;
        end else if (drain) begin
            x_count <= x_count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/gcd_demux.sv
// Registered 1-to-2 demux steering in_data to slot A or B by in_sel; optional counters via GCD_DEMUX_COUNT_EN.
// Latency: one cycle from accept to x_valid.
// Backpressure: in_ready reflects only the selected slot, so a stalled consumer blocks only its own path.
module gcd_demux
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
`ifdef GCD_DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef GCD_DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
`endif
);

    sel_t sel;
    logic a_can_load;
    logic b_can_load;
    logic accept;
    logic load_a;
    logic load_b;

    assign sel      = sel_t'(in_sel);
    assign in_ready = (sel == SEL_B) ? b_can_load : a_can_load;
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && (sel == SEL_A);
    assign load_b   = accept && (sel == SEL_B);

    gcd_demux_slot #(
        .WIDTH(WIDTH)
`ifdef GCD_DEMUX_COUNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .load     (load_a),
        .load_data(in_data),
        .can_load (a_can_load),
        .x_data   (a_data),
        .x_valid  (a_valid),
        .x_ready  (a_ready)
`ifdef GCD_DEMUX_COUNT_EN
        ,
        .x_count  (a_count)
`endif
    );

    gcd_demux_slot #(
        .WIDTH(WIDTH)
`ifdef GCD_DEMUX_COUNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .load     (load_b),
        .load_data(in_data),
        .can_load (b_can_load),
        .x_data   (b_data),
        .x_valid  (b_valid),
        .x_ready  (b_ready)
`ifdef GCD_DEMUX_COUNT_EN
        ,
        .x_count  (b_count)
`endif
    );

endmodule
